// File: rtl/slot_sched_pkg.sv
// rtl/slot_sched_pkg.sv - shared types, defaults and helpers for slot_scheduler
package slot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_CYC_DEF = 64;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first pending bit at or above ptr
module rr_arbiter
    import slot_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    // Walk offsets from farthest to nearest so the closest hit to ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        valid = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (pending[idx]) begin
                sel   = idx[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_scheduler.sv
// rtl/slot_scheduler.sv - per-frame round-robin slot scheduler; SLOT_SCHED_WATCHDOG_EN adds a grant watchdog
module slot_scheduler
    import slot_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             overrun,
    output logic             ovr_pulse,
    output logic             timeout,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] sel_q;
    logic             sel_valid;
    logic             ovr_cond;

`ifdef SLOT_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    logic [WD_W-1:0] wdog;
`else
    assign timeout = 1'b0;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .sel     (sel),
        .valid   (sel_valid)
    );

    assign busy = (state == ARB) || (state == GRANT);

    // A completion arriving with the strobe still counts; anything else left over is dropped work.
    assign ovr_cond = ((state == GRANT) && !done[sel_q]) || (pending != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            ptr       <= '0;
            sel_q     <= '0;
            grant     <= '0;
            overrun   <= 1'b0;
            ovr_pulse <= 1'b0;
            frame_cnt <= '0;
`ifdef SLOT_SCHED_WATCHDOG_EN
            wdog      <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            ovr_pulse <= 1'b0;
            if (frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;

            if (en_i) begin
                pending   <= req;
                grant     <= '0;
                state     <= ARB;
                frame_cnt <= '0;
                if (ovr_cond) begin
                    ovr_pulse <= 1'b1;
                    overrun   <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: ;
                    ARB: begin
                        if (!sel_valid) begin
                            state <= IDLE;
                        end else begin
                            grant        <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                            pending[sel] <= 1'b0;
                            ptr          <= IDX_W'(next_idx(int'(sel), N_REQ));
                            sel_q        <= sel;
                            state        <= GRANT;
`ifdef SLOT_SCHED_WATCHDOG_EN
                            wdog         <= '0;
`endif
                        end
                    end
                    GRANT: begin
                        if (done[sel_q]) begin
                            grant <= '0;
                            state <= ARB;
                        end
`ifdef SLOT_SCHED_WATCHDOG_EN
                        else if (wdog == WD_W'(TMO_CYC - 1)) begin
                            grant   <= '0;
                            timeout <= 1'b1;
                            state   <= ARB;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slot_scheduler.sv
// tb/tb_slot_scheduler.sv - scoreboard bench for slot_scheduler grant order, overrun, reset and frame counter
module tb_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en_i;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       busy;
    logic       overrun;
    logic       ovr_pulse;
    logic       timeout;
    logic [7:0] frame_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    int         exp_q[$];
    int         exp_i;
    logic [3:0] resp_done = 4'b0;
    logic [3:0] man_done = 4'b0;
    logic [3:0] prev_grant = 4'b0;
    bit         auto_done = 1'b0;
    int         hold = 0;

    assign done = resp_done | man_done;

    slot_scheduler #(.N_REQ(4), .CNT_W(8), .TMO_CYC(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (en_i),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_pulse (ovr_pulse),
        .timeout   (timeout),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Scoreboard: every new grant must match the next expected requester index.
    always @(negedge clk) begin
        if (reset_n && grant != 4'b0 && grant != prev_grant) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 32'(grant), 32'h0);
            end else begin
                exp_i = exp_q.pop_front();
                check("grant_order", 32'(grant), 32'(onehot(exp_i)));
            end
        end
        prev_grant = grant;
    end

    always @(negedge clk) begin
        if (auto_done && grant != 4'b0) begin
            hold++;
            resp_done = (hold == 3) ? grant : 4'b0;
        end else begin
            hold = 0;
            resp_done = 4'b0;
        end
    end

    task automatic start_frame(input logic [3:0] r);
        req  = r;
        en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        req  = 4'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 50 && grant == 4'b0; i++) @(negedge clk);
        check(tag, 32'(grant != 4'b0), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        en_i    = 1'b0;
        req     = 4'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_ovr_pulse", 32'(ovr_pulse), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frame 1011 from pointer 0
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        auto_done = 1'b1;
        start_frame(4'b1011);
        check("f1_busy_arb", 32'(busy), 32'h1);
        check("f1_cnt_clr", 32'(frame_cnt), 32'h0);
        check("f1_grant_lat1", 32'(grant), 32'h0);
        @(negedge clk);
        check("f1_grant_lat2", 32'(grant), 32'h1);
        wait_idle("f1_idle");
        check("f1_overrun", 32'(overrun), 32'h0);

        // Move pointer to 2, then full-request frame must rotate from there
        exp_q.push_back(1);
        start_frame(4'b0010);
        wait_idle("f2_idle");
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
        start_frame(4'b1111);
        wait_idle("f3_idle");
        check("f3_overrun", 32'(overrun), 32'h0);

        // Overrun: done withheld, next strobe after 40 cycles
        auto_done = 1'b0;
        exp_q.push_back(2);
        start_frame(4'b0111);
        repeat (40) @(negedge clk);
        check("ov_held", 32'(grant), 32'h4);
        exp_q.push_back(0);
        req  = 4'b0001;
        en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        req  = 4'b0;
        check("ov_grant_drop", 32'(grant), 32'h0);
        check("ov_pulse", 32'(ovr_pulse), 32'h1);
        check("ov_sticky", 32'(overrun), 32'h1);
        check("ov_busy_arb", 32'(busy), 32'h1);
        @(negedge clk);
        check("ov_pulse_end", 32'(ovr_pulse), 32'h0);
        check("ov_sticky2", 32'(overrun), 32'h1);
        check("ov_new_grant", 32'(grant), 32'h1);

        // Reset while granted: grant must drop without waiting for a clock
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_grant", 32'(grant), 32'h0);
        check("rst_mid_overrun", 32'(overrun), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Last done coincides with the strobe
        exp_q.push_back(0);
        start_frame(4'b0001);
        wait_grant("sim_first_grant");
        man_done = 4'b0001;
        req      = 4'b0010;
        en_i     = 1'b1;
        exp_q.push_back(1);
        @(negedge clk);
        man_done = 4'b0;
        en_i     = 1'b0;
        req      = 4'b0;
        check("sim_no_pulse", 32'(ovr_pulse), 32'h0);
        check("sim_grant_gap", 32'(grant), 32'h0);
        @(negedge clk);
        check("sim_grant_2cyc", 32'(grant), 32'h2);
        check("sim_no_overrun", 32'(overrun), 32'h0);
        auto_done = 1'b1;
        wait_idle("sim_idle");

        // Empty frame and frame counter saturation
        start_frame(4'b0000);
        check("empty_arb", 32'(busy), 32'h1);
        @(negedge clk);
        check("empty_idle", 32'(busy), 32'h0);
        check("empty_grant", 32'(grant), 32'h0);
        repeat (260) @(negedge clk);
        check("cnt_saturate", 32'(frame_cnt), 32'hff);
        check("empty_still_idle", 32'(busy), 32'h0);

`ifdef SLOT_SCHED_WATCHDOG_EN
        // Pointer is 2 here; requesters 0 and 1 follow in order
        begin
            int hi;
            hi = 0;
            auto_done = 1'b0;
            exp_q.push_back(0); exp_q.push_back(1);
            start_frame(4'b0011);
            wait_grant("wd_grant");
            for (int i = 0; i < 200 && grant != 4'b0; i++) begin
                hi++;
                @(negedge clk);
            end
            check("wd_hold_cycles", 32'(hi), 32'd64);
            check("wd_timeout", 32'(timeout), 32'h1);
            @(negedge clk);
            check("wd_next_grant", 32'(grant), 32'h2);
            auto_done = 1'b1;
            wait_idle("wd_idle");
        end
`else
        check("no_wd_timeout", 32'(timeout), 32'h0);
`endif

        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slot_scheduler.md
# slot_scheduler

Round-robin scheduler that shares one time-multiplexed datapath resource (e.g. the baseband MAC) among N requesters inside each sample frame. A frame is delimited by the clock-enable strobe from the clock and reset unit (en960k or en32k) on the 240 MHz clock. Each requester raising its request is granted at most once per frame. A per-frame overrun flag reports frames whose work did not finish before the next strobe.

## Interface
- N_REQ, 4: number of requesters, 2..8
- CNT_W, 8: width of the frame cycle counter; 8 bits cover the 250-cycle 960 kHz frame
- TMO_CYC, 64: grant timeout in cycles; used only with the watchdog macro
- clk  in  1  system clock (clk240m)
- reset_n  in  1  asynchronous, active-low reset
- en_i  in  1  frame-start strobe, one cycle wide
- req  in  N_REQ  per-requester request level, sampled only on en_i
- done  in  N_REQ  per-requester completion pulse, honoured only on the granted line
- grant  out  N_REQ  one-hot grant, registered; all zero when idle
- busy  out  1  high while the state is ARB or GRANT
- overrun  out  1  sticky; set on frame overrun; cleared only by reset
- ovr_pulse  out  1  one-cycle pulse per overrun event
- timeout  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out
- frame_cnt  out  CNT_W  cycles since the last en_i, saturating at all-ones

## Operation
- Reset values: grant=0, busy=0, overrun=0, ovr_pulse=0, timeout=0, frame_cnt=0, pending mask=0, round-robin pointer=0, state=IDLE.
- States and transitions:
  - IDLE: no work pending. Goes to ARB on en_i.
  - ARB: if pending=0, go to IDLE. Otherwise select the first set pending bit at or above the pointer, wrapping modulo N_REQ. Then grant<=onehot(sel), clear pending[sel], pointer<=(sel+1) mod N_REQ, go to GRANT.
  - GRANT: hold grant. When done[sel] is seen: grant<=0, go to ARB. done on any other line is ignored.
- en_i in any state:
  - pending<=req as sampled in that cycle; grant<=0; state<=ARB; frame_cnt<=0.
  - Overrun condition: state is GRANT without done[sel] in the same cycle, or pending≠0 after that cycle's updates.
  - On overrun: ovr_pulse=1 for one cycle and overrun<=1. Unserved work from the old frame is dropped.
- en_i and done[sel] in the same cycle: the completion counts. No overrun results if nothing else is pending.
- The pointer is not reset on en_i. Fairness carries across frames.
- req=0 at en_i: ARB goes to IDLE the following cycle and no grant is issued.
- Reset asserted mid-grant: grant drops asynchronously and immediately. All state returns to reset values.

## Timing
- en_i in cycle 0: ARB in cycle 1, grant visible in cycle 2.
- done[sel] in cycle k: grant low in cycle k+1, next grant in cycle k+2.
- Minimum spacing between consecutive grants is 2 cycles. Serving all N requesters with single-cycle work takes 2·N_REQ+1 cycles after en_i.
- busy matches the registered state. ovr_pulse is registered and occurs in the cycle after the en_i that caused it.
- frame_cnt increments every cycle and saturates at 2^CNT_W−1.

## Configuration
- SLOT_SCHED_WATCHDOG_EN defined:
  - A counter runs in GRANT. When it reaches TMO_CYC without done, grant<=0, timeout<=1 (sticky), and the state goes to ARB.
  - The counter clears on every grant.
- Not defined: there is no counter, timeout is tied 0, and a grant is held until done or en_i.

## Structure
- Package slot_sched_pkg holds:
  - the state enum (IDLE, ARB, GRANT)
  - the default localparams
  - a function for next index modulo N_REQ
- Sub-module rr_arbiter: purely combinational. Inputs are the pending mask and the pointer; outputs are the selected index and a valid bit. The selection is a priority search that wraps modulo N_REQ.
- The top level holds the FSM, the pending mask, the pointer, the flags, frame_cnt and the optional watchdog.

## Test plan
- Single frame, N_REQ=4: req=4'b1011 at en_i, done 3 cycles after each grant. Required grant order 0001, 0010, 1000, then busy=0; overrun stays 0.
- Fairness: pointer at 2 after a frame; next frame with req=4'b1111. Required grant order 2, 3, 0, 1.
- Overrun: req=4'b0111, done withheld, en_i after 40 cycles. Required: grant=0 the next cycle, ovr_pulse for one cycle, overrun=1, new frame starts in ARB.
- Simultaneous: the last done of a frame arrives in the same cycle as en_i. Required: no ovr_pulse, and the new frame's first grant appears 2 cycles later.
- Empty frame: req=0 at en_i. Required: ARB then IDLE, grant never asserted, frame_cnt saturates at 255 without further en_i.
- Watchdog (SLOT_SCHED_WATCHDOG_EN, TMO_CYC=64): done withheld. Required: grant drops 64 cycles after assertion, timeout=1, the next pending requester is granted 2 cycles later. Reset_n low mid-grant clears grant immediately.
